host_reg_writer: RTL and testbench
==================================

Name: host_reg_writer

Overview:
- Host-side producer of the opl3_reg_wr interface consumed by channels, operators and the other register-snooping blocks.
- Accepts OPL3-style 4-port bus writes:
  - A0=0 latches the register address.
  - A0=1 writes data.
  - A1 selects the bank.
- Buffers completed writes in a FIFO and issues them as single-cycle opl3_reg_wr.valid pulses, spaced by a programmable minimum gap.
- Exposes a host status byte with FIFO-full and overflow flags.

Parameters:
- FIFO_DEPTH, 8, number of buffered register writes; power of 2, ≥2.
- WR_SPACING, 4, minimum clk cycles between consecutive opl3_reg_wr.valid pulses; ≥1, where 1 means back-to-back.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- host_wr  in  1  single-cycle host write strobe.
- host_rd  in  1  single-cycle host status read strobe.
- host_addr  in  2  {A1, A0}; A1 = bank, A0 = 0 address / 1 data.
- host_din  in  8  host write data.
- host_dout  out  8  status byte {fifo_full, overflow, fifo_empty, 5'b0}; registered.
- host_busy  out  1  high while the FIFO is non-empty or the spacing counter is non-zero.
- opl3_reg_wr  out  opl3_reg_wr_t  {valid, bank_num, address[7:0], data[7:0]}.

Behaviour:
- Reset values:
  - All outputs 0; opl3_reg_wr = 0.
  - FIFO empty; wr/rd pointers 0.
  - Address latch 0x00, bank latch 0, overflow 0, spacing counter 0, state IDLE.
  - Reset asserted mid-burst discards all queued writes; no valid pulse is produced on the cycle reset deasserts.
- Address write (host_wr, A0=0):
  - addr_latch <= host_din; bank_latch <= A1.
  - Nothing is queued.
- Data write (host_wr, A0=1):
  - Push {bank_latch, addr_latch, host_din} into the FIFO.
  - The latched bank is used, not the A1 of the data write.
  - addr_latch is retained, so repeated data writes re-target the same register.
- Full/overflow:
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and overflow <= 1.
- Overflow is sticky; it clears on the cycle after a host_rd that returned it as 1 (read-to-clear).
- host_dout updates on host_rd from the flag values of that cycle; it holds between reads.
- Issue FSM, three states:
  - IDLE: if FIFO non-empty → ISSUE.
  - ISSUE: pop the head entry; register it onto opl3_reg_wr with valid=1 for exactly one cycle. Then:
    - WR_SPACING>1 → HOLD, with counter loaded to WR_SPACING-1.
    - WR_SPACING=1 → stay in ISSUE if the FIFO is still non-empty after the pop, else IDLE.
  - HOLD: decrement the counter. At 1 → ISSUE if non-empty, else IDLE.
- Latency: a data write on cycle N with an empty FIFO and IDLE state produces valid on cycle N+2.
- Entries issue in write order.
- opl3_reg_wr fields other than valid hold their last value when valid=0.
- Simultaneous host_wr and host_rd: both are processed. host_dout reflects pre-write flags.
- FIFO pointers wrap modulo FIFO_DEPTH. count is (log2(FIFO_DEPTH)+1) bits wide.

Optional Feature:
- Macro: HOST_REG_WRITER_OPL2_COMPAT_EN.
- When defined:
  - The block tracks a local NEW bit, updated on each issued write to bank 1 address 0x05 (data[0]); reset value 0.
  - While NEW=0, any issued write with bank_num=1 and address ≠ 0x04/0x05 goes out with bank_num=0, modelling OPL2-mode bank aliasing.
  - Remapping applies at issue time, not at push time.
- When undefined: bank_num passes through unmodified and no NEW tracking logic exists.

Test Plan:
- Write A=0 0x20, then A=1 0x41 → one valid pulse 2 cycles after the data write: bank 0, addr 0x20, data 0x41; host_busy high for WR_SPACING cycles after the pulse.
- Write A=2 0xC3, then A=1 0x30 → issued as bank 1, addr 0xC3, data 0x30 (latched bank used).
- With WR_SPACING=4, burst 5 data writes on consecutive cycles to addr 0xB0, data 0..4 → five pulses exactly 4 cycles apart, data order 0,1,2,3,4.
- Fill FIFO_DEPTH=8 entries while issue is stalled in HOLD, then push a 9th → 9th dropped, host_rd returns 0xC0 (full+overflow); second host_rd after drain returns 0x20 (empty only).
- Assert reset with 3 entries queued → no further valid pulses, host_dout=0, host_busy=0; a subsequent data write is issued normally.
- HOST_REG_WRITER_OPL2_COMPAT_EN: bank-1 write to 0xA0 with NEW=0 → bank_num 0. Then bank-1 write 0x05=0x01, then bank-1 write to 0xA0 → bank_num 1.

Source files
------------

// File: rtl/opl3_reg_wr_pkg.sv
// rtl/opl3_reg_wr_pkg.sv - register-write record shared by the OPL3 register-snooping blocks
package opl3_reg_wr_pkg;

  typedef struct packed {
    logic       valid;
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_wr_t;

endpackage

// File: rtl/host_reg_writer.sv
// rtl/host_reg_writer.sv - OPL3 host bus to opl3_reg_wr bridge with write FIFO and issue spacing
// Optional OPL2 bank aliasing: HOST_REG_WRITER_OPL2_COMPAT_EN
module host_reg_writer
  import opl3_reg_wr_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int WR_SPACING = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         host_wr,
  input  logic         host_rd,
  input  logic [1:0]   host_addr,
  input  logic [7:0]   host_din,
  output logic [7:0]   host_dout,
  output logic         host_busy,
  output opl3_reg_wr_t opl3_reg_wr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (WR_SPACING > 1) ? $clog2(WR_SPACING) : 1;
  localparam logic [CW-1:0] SPACE_LOAD = CW'(WR_SPACING - 1);
  localparam logic [PW:0]   DEPTH_C    = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [16:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]  r_count;
  logic [7:0]   r_addr_latch;
  logic         r_bank_latch;
  logic         r_ovf;
  logic [CW-1:0] r_space;
  logic [7:0]   r_dout;
  opl3_reg_wr_t r_out;

  logic         w_empty;
  logic         w_full;
  logic         w_push_req;
  logic         w_push;
  logic         w_drop;
  logic         w_issue;
  logic         w_space_dec;
  logic         w_bank_out;
  logic [16:0]  w_head;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_head     = r_mem[r_rptr];
  assign w_push_req = host_wr & host_addr[0];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign w_push     = w_push_req & (~w_full | w_issue);
  assign w_drop     = w_push_req & ~w_push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_ISSUE;
      S_ISSUE: begin
        if (WR_SPACING > 1) w_next = S_HOLD;
        else                w_next = w_empty ? S_IDLE : S_ISSUE;
      end
      S_HOLD:  if (r_space == CW'(1)) w_next = w_empty ? S_IDLE : S_ISSUE;
      default: w_next = S_IDLE;
    endcase
  end

  // The pulse is registered on the edge that enters ISSUE, giving write-to-valid latency of 2
  always_comb begin
    w_issue     = (w_next == S_ISSUE);
    w_space_dec = (r_state == S_HOLD);
  end

`ifdef HOST_REG_WRITER_OPL2_COMPAT_EN
  logic r_new;
  logic w_is_new_reg;
  logic w_is_bank1_ctl;

  assign w_is_bank1_ctl = (w_head[15:8] == 8'h04) || (w_head[15:8] == 8'h05);
  assign w_is_new_reg   = w_head[16] && (w_head[15:8] == 8'h05);
  assign w_bank_out     = w_head[16] && (r_new || w_is_bank1_ctl);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_new <= 1'b0;
    else if (w_issue && w_is_new_reg)  r_new <= w_head[0];
  end
`else
  assign w_bank_out = w_head[16];
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_bank_latch, r_addr_latch, host_din};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_addr_latch <= 8'h00;
      r_bank_latch <= 1'b0;
      r_ovf        <= 1'b0;
      r_space      <= '0;
      r_dout       <= 8'h00;
      r_out        <= '0;
    end else begin
      if (host_wr && !host_addr[0]) begin
        r_addr_latch <= host_din;
        r_bank_latch <= host_addr[1];
      end
      if (w_push)  r_wptr <= r_wptr + PW'(1);
      if (w_issue) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A fresh drop outranks the read-to-clear of the previous overflow
      r_ovf <= w_drop | (r_ovf & ~host_rd);
      if (host_rd) r_dout <= {w_full, r_ovf, w_empty, 5'b0};
      if (w_issue)                          r_space <= SPACE_LOAD;
      else if (w_space_dec && r_space != '0) r_space <= r_space - 1'b1;
      if (w_issue) begin
        r_out.valid    <= 1'b1;
        r_out.bank_num <= w_bank_out;
        r_out.address  <= w_head[15:8];
        r_out.data     <= w_head[7:0];
      end else begin
        r_out.valid    <= 1'b0;
      end
    end
  end

  assign host_dout   = r_dout;
  assign host_busy   = ~w_empty | (r_space != '0);
  assign opl3_reg_wr = r_out;

endmodule

// File: tb/tb_host_reg_writer.sv
// tb/tb_host_reg_writer.sv - scoreboard bench for host_reg_writer
module tb_host_reg_writer;
  import opl3_reg_wr_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int WR_SPACING = 4;
`ifdef HOST_REG_WRITER_OPL2_COMPAT_EN
  localparam logic BANK1_NEW0 = 1'b0;
`else
  localparam logic BANK1_NEW0 = 1'b1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         host_wr = 1'b0;
  logic         host_rd = 1'b0;
  logic [1:0]   host_addr = 2'b00;
  logic [7:0]   host_din = 8'h00;
  logic [7:0]   host_dout;
  logic         host_busy;
  opl3_reg_wr_t opl3_reg_wr;

  typedef struct {
    logic       bank;
    logic [7:0] addr;
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   pulse_cnt = 0;
  int   cyc = 0;
  int   k0;
  int   pc0;

  host_reg_writer #(.FIFO_DEPTH(FIFO_DEPTH), .WR_SPACING(WR_SPACING)) dut (
    .clk(clk), .reset(reset), .host_wr(host_wr), .host_rd(host_rd),
    .host_addr(host_addr), .host_din(host_din), .host_dout(host_dout),
    .host_busy(host_busy), .opl3_reg_wr(opl3_reg_wr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected write
  always @(negedge clk) begin
    if (opl3_reg_wr.valid === 1'b1) begin
      pulse_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_pulse", {15'd0, opl3_reg_wr}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_bank", 32'(opl3_reg_wr.bank_num), 32'(mon_e.bank));
        check("pulse_addr", 32'(opl3_reg_wr.address), 32'(mon_e.addr));
        check("pulse_data", 32'(opl3_reg_wr.data), 32'(mon_e.data));
        if (mon_e.exp_cyc >= 0) check("pulse_cycle", 32'(cyc), 32'(mon_e.exp_cyc));
      end
    end
  end

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    host_wr   = 1'b1;
    host_addr = a;
    host_din  = d;
    @(negedge clk);
    host_wr   = 1'b0;
  endtask

  task automatic bus_rd();
    host_rd = 1'b1;
    @(negedge clk);
    host_rd = 1'b0;
  endtask

  task automatic expect_wr(input logic b, input logic [7:0] a, input logic [7:0] d, input int c);
    exp_t e;
    e.bank = b; e.addr = a; e.data = d; e.exp_cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((host_busy || sb.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 300), 32'h1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(host_dout), 32'h0);
    check("rst_busy", 32'(host_busy), 32'h0);
    check("rst_out", 32'(opl3_reg_wr), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    bus_rd();
    check("idle_status", 32'(host_dout), 32'h20);

    // Single write: latency 2, busy covers the pulse cycle plus spacing
    bus_wr(2'b00, 8'h20);
    k0 = cyc;
    expect_wr(1'b0, 8'h20, 8'h41, k0 + 2);
    bus_wr(2'b01, 8'h41);
    check("busy_queued", 32'(host_busy), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("busy_window", 32'(host_busy), (i < 5) ? 32'h1 : 32'h0);
    end
    wait_idle();
    check("hold_fields", {15'd0, opl3_reg_wr}, {15'd0, 1'b0, 1'b0, 8'h20, 8'h41});

    // Latched bank from the address write is used
    bus_wr(2'b10, 8'hC3);
    k0 = cyc;
    expect_wr(BANK1_NEW0, 8'hC3, 8'h30, k0 + 2);
    bus_wr(2'b01, 8'h30);
    wait_idle();

    // Burst of five: pulses exactly WR_SPACING apart, in order
    bus_wr(2'b00, 8'hB0);
    k0 = cyc;
    for (int i = 0; i < 5; i++) begin
      expect_wr(1'b0, 8'hB0, 8'(i), k0 + 2 + 4 * i);
      bus_wr(2'b01, 8'(i));
    end
    wait_idle();

    // Overflow: 12 back-to-back pushes; pops at writes 1,5,9 make the 12th the first drop
    bus_wr(2'b00, 8'h40);
    k0 = cyc;
    for (int i = 0; i < 12; i++) begin
      if (i <= 10) expect_wr(1'b0, 8'h40, 8'(i), k0 + 2 + 4 * i);
      bus_wr(2'b01, 8'(i));
    end
    bus_rd();
    check("status_full_ovf", 32'(host_dout), 32'hC0);
    wait_idle();
    bus_rd();
    check("status_after_clear", 32'(host_dout), 32'h20);

    // Reset mid-burst discards queued writes
    bus_wr(2'b00, 8'h60);
    k0 = cyc;
    expect_wr(1'b0, 8'h60, 8'h00, k0 + 2);
    for (int i = 0; i < 4; i++) bus_wr(2'b01, 8'(i));
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(host_busy), 32'h0);
    check("midrst_dout", 32'(host_dout), 32'h0);
    check("midrst_out", 32'(opl3_reg_wr), 32'h0);
    repeat (2) @(negedge clk);
    pc0 = pulse_cnt;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("no_pulse_after_rst", 32'(pulse_cnt), 32'(pc0));
    check("busy_after_rst", 32'(host_busy), 32'h0);
    bus_wr(2'b00, 8'h61);
    k0 = cyc;
    expect_wr(1'b0, 8'h61, 8'h77, k0 + 2);
    bus_wr(2'b01, 8'h77);
    wait_idle();

`ifdef HOST_REG_WRITER_OPL2_COMPAT_EN
    bus_wr(2'b10, 8'hA0);
    expect_wr(1'b0, 8'hA0, 8'h11, -1);
    bus_wr(2'b01, 8'h11);
    wait_idle();
    bus_wr(2'b10, 8'h05);
    expect_wr(1'b1, 8'h05, 8'h01, -1);
    bus_wr(2'b01, 8'h01);
    wait_idle();
    bus_wr(2'b10, 8'hA0);
    expect_wr(1'b1, 8'hA0, 8'h22, -1);
    bus_wr(2'b01, 8'h22);
    wait_idle();
`endif

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
